// File: rtl/icache_pkg.sv
// Shared types and address-field widths for the instruction-cache controller.
`ifndef WAYS
`define WAYS 2
`endif

package icache_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;

    localparam int ICACHE_IDX_BITS = 5;
    localparam int ICACHE_TAG_BITS = 8;
    localparam int BLK_OFFSET_BITS = 3;
    localparam int BLK_BITS        = ICACHE_IDX_BITS + ICACHE_TAG_BITS;
    localparam int MEM_TAG_BITS    = 4;

    typedef struct packed {
        logic                    valid;
        logic [MEM_TAG_BITS-1:0] mem_tag;
        logic [BLK_BITS-1:0]     blk;
    } mshr_entry_t;

    // Block number back to a block-aligned bus address (upper half is zero).
    function automatic logic [31:0] blk_to_addr(input logic [BLK_BITS-1:0] blk);
        return {16'b0, blk, 3'b0};
    endfunction

endpackage

// File: rtl/icache_mshr.sv
// Outstanding-miss table: allocates on accepted loads, frees on matching fill tags.
module icache_mshr
    import icache_pkg::*;
#(
    parameter int MSHR_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alloc_en,
    input  logic [MEM_TAG_BITS-1:0] alloc_tag,
    input  logic [BLK_BITS-1:0]     alloc_blk,
    input  logic [MEM_TAG_BITS-1:0] fill_tag,
    input  logic [BLK_BITS-1:0]     strm_blk,
    input  logic [BLK_BITS-1:0]     miss_blk,
    output logic                    full,
    output logic                    strm_present,
    output logic                    miss_present,
    output logic                    fill_hit,
    output logic [BLK_BITS-1:0]     fill_blk
);

    mshr_entry_t entries [MSHR_DEPTH];

    logic [MSHR_DEPTH-1:0] alloc_sel;
    logic [MSHR_DEPTH-1:0] fill_sel;
    logic                  alloc_found;

    always_comb begin
        full         = 1'b1;
        strm_present = 1'b0;
        miss_present = 1'b0;
        fill_hit     = 1'b0;
        fill_blk     = '0;
        fill_sel     = '0;
        alloc_sel    = '0;
        alloc_found  = 1'b0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (entries[i].valid) begin
                if (entries[i].blk == strm_blk) strm_present = 1'b1;
                if (entries[i].blk == miss_blk) miss_present = 1'b1;
                if (fill_tag != '0 && entries[i].mem_tag == fill_tag && !fill_hit) begin
                    fill_hit    = 1'b1;
                    fill_blk    = entries[i].blk;
                    fill_sel[i] = 1'b1;
                end
            end else begin
                full = 1'b0;
                if (!alloc_found) begin
                    alloc_sel[i] = 1'b1;
                    alloc_found  = 1'b1;
                end
            end
        end
    end

    // Allocation only ever targets an invalid slot and a fill only a valid one,
    // so both can land in the same cycle without conflict.
    always_ff @(posedge clock) begin
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (reset) begin
                entries[i].valid <= 1'b0;
            end else begin
                if (fill_sel[i]) entries[i].valid <= 1'b0;
                if (alloc_en && alloc_sel[i]) begin
                    entries[i].valid   <= 1'b1;
                    entries[i].mem_tag <= alloc_tag;
                    entries[i].blk     <= alloc_blk;
                end
            end
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache controller: combinational hit path, miss stream with
// sequential prefetch, tagged bus loads tracked in an MSHR, and cache fills.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int MSHR_DEPTH     = 4,
    parameter int PREFETCH_LINES = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [`WAYS-1:0][31:0]             proc2Icache_addr,
    output logic [`WAYS-1:0][63:0]             Icache_data_out,
    output logic [`WAYS-1:0]                   Icache_valid_out,
    output logic [`WAYS-1:0][ICACHE_IDX_BITS-1:0] cache_rd_idx,
    output logic [`WAYS-1:0][ICACHE_TAG_BITS-1:0] cache_rd_tag,
    input  logic [`WAYS-1:0][63:0]             cache_rd_data,
    input  logic [`WAYS-1:0]                   cache_rd_valid,
    output logic                               cache_wr_en,
    output logic [ICACHE_IDX_BITS-1:0]         cache_wr_idx,
    output logic [ICACHE_TAG_BITS-1:0]         cache_wr_tag,
    output logic [63:0]                        cache_wr_data,
    output logic [1:0]                         proc2mem_command,
    output logic [31:0]                        proc2mem_addr,
    input  logic [MEM_TAG_BITS-1:0]            mem2proc_response,
    input  logic [63:0]                        mem2proc_data,
    input  logic [MEM_TAG_BITS-1:0]            mem2proc_tag
);

    localparam int CNT_W = $clog2(PREFETCH_LINES + 1);

    logic                strm_active;
    logic [BLK_BITS-1:0] strm_blk;
    logic [CNT_W-1:0]    strm_cnt;

    logic                miss_found;
    logic [BLK_BITS-1:0] miss_blk;
    logic                mshr_full;
    logic                strm_present;
    logic                miss_present;
    logic                fill_hit;
    logic [BLK_BITS-1:0] fill_blk;
    logic [MEM_TAG_BITS-1:0] fill_tag;

    logic start_strm;
    logic issue;
    logic accepted;
    logic skip;
    logic unused_addr_bits;

    always_comb begin
        for (int w = 0; w < `WAYS; w++) begin
            cache_rd_idx[w]     = reset ? '0 : proc2Icache_addr[w][7:3];
            cache_rd_tag[w]     = reset ? '0 : proc2Icache_addr[w][15:8];
            Icache_data_out[w]  = reset ? '0 : cache_rd_data[w];
            Icache_valid_out[w] = reset ? 1'b0 : cache_rd_valid[w];
        end
    end

    always_comb begin
        unused_addr_bits = 1'b0;
        for (int w = 0; w < `WAYS; w++) begin
            unused_addr_bits = unused_addr_bits ^ (^{proc2Icache_addr[w][31:16], proc2Icache_addr[w][2:0]});
        end
    end

    // The oldest missing way in program order drives the miss stream.
    always_comb begin
        miss_found = 1'b0;
        miss_blk   = '0;
        for (int w = 0; w < `WAYS; w++) begin
            if (!miss_found && !cache_rd_valid[w]) begin
                miss_found = 1'b1;
                miss_blk   = proc2Icache_addr[w][15:3];
            end
        end
    end

    assign start_strm = !reset && miss_found && !miss_present &&
                        (!strm_active || miss_blk != strm_blk);
    assign issue      = !reset && strm_active && !strm_present && !mshr_full;
    assign accepted   = issue && (mem2proc_response != '0);
    assign skip       = !reset && strm_active && strm_present;
    assign fill_tag   = reset ? '0 : mem2proc_tag;

    icache_mshr #(
        .MSHR_DEPTH(MSHR_DEPTH)
    ) u_mshr (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (accepted),
        .alloc_tag    (mem2proc_response),
        .alloc_blk    (strm_blk),
        .fill_tag     (fill_tag),
        .strm_blk     (strm_blk),
        .miss_blk     (miss_blk),
        .full         (mshr_full),
        .strm_present (strm_present),
        .miss_present (miss_present),
        .fill_hit     (fill_hit),
        .fill_blk     (fill_blk)
    );

    // A redirect overrides any advance; the accepted load of the old stream
    // still lands in the MSHR and completes normally.
    always_ff @(posedge clock) begin
        if (reset) begin
            strm_active <= 1'b0;
            strm_cnt    <= '0;
        end else if (start_strm) begin
            strm_active <= 1'b1;
            strm_blk    <= miss_blk;
            strm_cnt    <= CNT_W'(PREFETCH_LINES);
        end else if (accepted || skip) begin
            strm_blk <= strm_blk + BLK_BITS'(1);
            strm_cnt <= strm_cnt - CNT_W'(1);
            if (strm_cnt == CNT_W'(1)) strm_active <= 1'b0;
        end
    end

    always_comb begin
        proc2mem_command = issue ? BUS_LOAD : BUS_NONE;
        proc2mem_addr    = issue ? blk_to_addr(strm_blk) : '0;
        cache_wr_en      = fill_hit;
        cache_wr_idx     = fill_hit ? fill_blk[ICACHE_IDX_BITS-1:0] : '0;
        cache_wr_tag     = fill_hit ? fill_blk[BLK_BITS-1:ICACHE_IDX_BITS] : '0;
        cache_wr_data    = fill_hit ? mem2proc_data : '0;
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a small behavioural cache array behind it.
`ifndef WAYS
`define WAYS 2
`endif

module tb_icache_ctrl;
    import icache_pkg::*;

    logic                   clock;
    logic                   reset;
    logic [`WAYS-1:0][31:0] proc2Icache_addr;
    logic [`WAYS-1:0][63:0] Icache_data_out;
    logic [`WAYS-1:0]       Icache_valid_out;
    logic [`WAYS-1:0][4:0]  cache_rd_idx;
    logic [`WAYS-1:0][7:0]  cache_rd_tag;
    logic [`WAYS-1:0][63:0] cache_rd_data;
    logic [`WAYS-1:0]       cache_rd_valid;
    logic                   cache_wr_en;
    logic [4:0]             cache_wr_idx;
    logic [7:0]             cache_wr_tag;
    logic [63:0]            cache_wr_data;
    logic [1:0]             proc2mem_command;
    logic [31:0]            proc2mem_addr;
    logic [3:0]             mem2proc_response;
    logic [63:0]            mem2proc_data;
    logic [3:0]             mem2proc_tag;

    int n_checks = 0;
    int n_fail   = 0;

    icache_ctrl #(
        .MSHR_DEPTH(4),
        .PREFETCH_LINES(4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .proc2Icache_addr  (proc2Icache_addr),
        .Icache_data_out   (Icache_data_out),
        .Icache_valid_out  (Icache_valid_out),
        .cache_rd_idx      (cache_rd_idx),
        .cache_rd_tag      (cache_rd_tag),
        .cache_rd_data     (cache_rd_data),
        .cache_rd_valid    (cache_rd_valid),
        .cache_wr_en       (cache_wr_en),
        .cache_wr_idx      (cache_wr_idx),
        .cache_wr_tag      (cache_wr_tag),
        .cache_wr_data     (cache_wr_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 32-line direct-mapped cache array; written lines are visible next cycle.
    logic        c_valid [32];
    logic [7:0]  c_tag   [32];
    logic [63:0] c_data  [32];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) c_valid[i] <= 1'b0;
        end else if (cache_wr_en) begin
            c_valid[cache_wr_idx] <= 1'b1;
            c_tag[cache_wr_idx]   <= cache_wr_tag;
            c_data[cache_wr_idx]  <= cache_wr_data;
        end
    end

    always_comb begin
        for (int w = 0; w < `WAYS; w++) begin
            cache_rd_valid[w] = c_valid[cache_rd_idx[w]] && (c_tag[cache_rd_idx[w]] == cache_rd_tag[w]);
            cache_rd_data[w]  = c_data[cache_rd_idx[w]];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_addr(input logic [31:0] a);
        for (int w = 0; w < `WAYS; w++) proc2Icache_addr[w] = a;
    endtask

    task automatic expect_load(input string tag, input logic [31:0] a);
        check_eq({tag, "_cmd"}, 64'(proc2mem_command), 64'(BUS_LOAD));
        check_eq({tag, "_addr"}, 64'(proc2mem_addr), 64'(a));
    endtask

    task automatic expect_none(input string tag);
        check_eq({tag, "_cmd"}, 64'(proc2mem_command), 64'(BUS_NONE));
        check_eq({tag, "_addr"}, 64'(proc2mem_addr), 64'h0);
    endtask

    initial begin
        reset             = 1'b1;
        set_addr(32'h0);
        mem2proc_response = 4'h0;
        mem2proc_data     = 64'h0;
        mem2proc_tag      = 4'h0;

        // Reset state
        cyc();
        cyc();
        expect_none("rst");
        check_eq("rst_wr_en", 64'(cache_wr_en), 64'h0);
        check_eq("rst_valid", 64'(Icache_valid_out), 64'h0);

        // Demand miss at 0x100 plus three prefetches, all accepted
        reset = 1'b0;
        set_addr(32'h0000_0100);
        mem2proc_response = 4'h1;
        #1;
        expect_none("miss_first_cycle");
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem2proc_response = 4'(i + 1);
            #1;
            expect_load($sformatf("stream%0d", i), 32'h100 + 32'(8 * i));
            cyc();
        end
        mem2proc_response = 4'h0;

        // Fill tag 1 -> idx 0, tag 0x01; hit the next cycle
        mem2proc_tag  = 4'h1;
        mem2proc_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        expect_none("stream_done");
        check_eq("fill_wr_en", 64'(cache_wr_en), 64'h1);
        check_eq("fill_wr_idx", 64'(cache_wr_idx), 64'h0);
        check_eq("fill_wr_tag", 64'(cache_wr_tag), 64'h01);
        check_eq("fill_wr_data", cache_wr_data, 64'hDEAD_BEEF_0000_0001);
        cyc();
        mem2proc_tag = 4'h0;
        #1;
        check_eq("hit_valid", 64'(Icache_valid_out[0]), 64'h1);
        check_eq("hit_data", Icache_data_out[0], 64'hDEAD_BEEF_0000_0001);
        check_eq("idle_wr_en", 64'(cache_wr_en), 64'h0);
        check_eq("idle_wr_data", cache_wr_data, 64'h0);
        mem2proc_tag = 4'h9;
        #1;
        check_eq("nomatch_wr_en", 64'(cache_wr_en), 64'h0);
        mem2proc_tag = 4'h0;

        // MSHR full: tags 2,3,4 outstanding, 0x3000 takes the last slot
        set_addr(32'h0000_3000);
        cyc();
        mem2proc_response = 4'h5;
        #1;
        expect_load("full_first", 32'h3000);
        cyc();
        mem2proc_response = 4'h6;
        #1;
        expect_none("full_stall0");
        cyc();
        #1;
        expect_none("full_stall1");
        mem2proc_tag  = 4'h3;
        mem2proc_data = 64'h0000_0000_0000_0110;
        #1;
        expect_none("full_free_cycle");
        check_eq("full_free_wr_idx", 64'(cache_wr_idx), 64'h2);
        cyc();
        mem2proc_tag = 4'h0;
        #1;
        expect_load("full_resume", 32'h3008);
        cyc();
        mem2proc_response = 4'h0;
        #1;
        expect_none("full_again");

        // Reset mid-miss, then rejected requests are retried
        reset = 1'b1;
        cyc();
        #1;
        expect_none("rst2");
        reset = 1'b0;
        set_addr(32'h0000_0100);
        mem2proc_tag = 4'h2;
        #1;
        check_eq("stale_tag_wr_en", 64'(cache_wr_en), 64'h0);
        cyc();
        mem2proc_tag = 4'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_load($sformatf("retry%0d", i), 32'h100);
            cyc();
        end
        mem2proc_response = 4'h7;
        #1;
        expect_load("retry_accept", 32'h100);
        cyc();
        for (int i = 1; i < 4; i++) begin
            mem2proc_response = 4'(7 + i);
            #1;
            expect_load($sformatf("retry_stream%0d", i), 32'h100 + 32'(8 * i));
            cyc();
        end
        mem2proc_response = 4'h0;
        #1;
        expect_none("retry_done");

        // Redirect while the stream sits at 0x108
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_addr(32'h0000_0100);
        cyc();
        mem2proc_response = 4'hB;
        #1;
        expect_load("redir_0x100", 32'h100);
        cyc();
        mem2proc_response = 4'h0;
        set_addr(32'h0000_2000);
        #1;
        expect_load("redir_0x108", 32'h108);
        cyc();
        mem2proc_response = 4'hC;
        #1;
        expect_load("redir_new", 32'h2000);
        cyc();
        mem2proc_response = 4'hD;
        #1;
        expect_load("redir_no_stale", 32'h2008);
        cyc();
        mem2proc_response = 4'hE;
        #1;
        expect_load("redir_2010", 32'h2010);
        cyc();
        mem2proc_response = 4'hF;
        mem2proc_tag      = 4'hB;
        mem2proc_data     = 64'h1111_2222_3333_4444;
        #1;
        expect_none("redir_full");
        check_eq("redir_fill_wr_en", 64'(cache_wr_en), 64'h1);
        check_eq("redir_fill_wr_idx", 64'(cache_wr_idx), 64'h0);
        check_eq("redir_fill_wr_tag", 64'(cache_wr_tag), 64'h01);
        cyc();
        mem2proc_tag = 4'h0;
        #1;
        expect_load("redir_2018", 32'h2018);
        cyc();
        mem2proc_response = 4'h0;

        // Block-number wrap, then reset with two loads outstanding
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_addr(32'h0000_FFF8);
        cyc();
        mem2proc_response = 4'h7;
        #1;
        expect_load("wrap_top", 32'hFFF8);
        cyc();
        mem2proc_response = 4'h8;
        #1;
        expect_load("wrap_zero", 32'h0000);
        cyc();
        mem2proc_response = 4'h0;
        reset = 1'b1;
        #1;
        expect_none("wrap_rst");
        cyc();
        reset = 1'b0;
        mem2proc_tag = 4'h7;
        #1;
        check_eq("wrap_stale7_wr_en", 64'(cache_wr_en), 64'h0);
        cyc();
        mem2proc_tag = 4'h8;
        #1;
        check_eq("wrap_stale8_wr_en", 64'(cache_wr_en), 64'h0);
        cyc();
        mem2proc_tag = 4'h0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
